// File: rtl/subca_ser_if.sv
`default_nettype none
// ============================================================================
//  Module      : subca_ser_if
//  Description : Request/result bundle for the bit-serial subtractor.
//                Carries ovf only when SUBCA_SER_OVF_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface subca_ser_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic         bout;
`ifdef SUBCA_SER_OVF_EN
  logic         ovf;

  modport master (output start, a, b, bin, input busy, done, q, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, q, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, q, bout);
  modport slave  (input start, a, b, bin, output busy, done, q, bout);
`endif
endinterface
`default_nettype wire

// File: rtl/subca_ser.sv
`default_nettype none
// ============================================================================
//  Module      : subca_ser
//  Description : Bit-serial W-bit subtractor, q = a - b - bin, LSB first.
//                Optional signed-overflow flag enabled by SUBCA_SER_OVF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module subca_ser #(
  parameter int W = 4
) (
  input  wire logic  ck,
  input  wire logic  rst_n,
  subca_ser_if.slave bus
);

  localparam int c_cw = (W > 1) ? $clog2(W) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic            w_load;
  logic            w_fin;
  logic            w_d;
  logic            w_br_nx;
  logic [W-1:0]    w_res_nx;

  logic [c_cw-1:0] r_cnt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_br;
  logic [W-2:0]    r_res;
  logic [W-1:0]    r_q;
  logic            r_bout;
  logic            r_busy;
  logic            r_done;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_fin      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nx = RUN;
          w_load     = 1'b1;
        end
      end
      RUN: begin
        if (r_cnt == c_last) begin
          w_state_nx = IDLE;
          w_fin      = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // One full-subtractor bit per cycle; the difference enters from the MSB so
  // after W cycles the first (LSB) difference bit has reached bit 0.
  assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_nx  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_res_nx = {w_d, r_res};

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_res  <= '0;
      r_q    <= '0;
      r_bout <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nx == RUN);
      r_done <= w_fin;
      if (w_load) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_br  <= bus.bin;
        r_res <= '0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_br_nx;
        r_res <= w_res_nx[W-1:1];
        r_cnt <= r_cnt + 1'b1;
        if (w_fin) begin
          r_q    <= w_res_nx;
          r_bout <= w_br_nx;
        end
      end
    end
  end

`ifdef SUBCA_SER_OVF_EN
  logic r_sa;
  logic r_sb;
  logic r_ovf;

  // Operand sign bits are shifted out during RUN, so they are kept aside.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_load) begin
        r_sa <= bus.a[W-1];
        r_sb <= bus.b[W-1];
      end
      if (w_fin) begin
        r_ovf <= (r_sa ^ r_sb) & (w_d ^ r_sa);
      end
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.q    = r_q;
  assign bus.bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_subca_ser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_subca_ser
//  Description : Self-checking bench for subca_ser (W=4) against an
//                arithmetic reference model; honours SUBCA_SER_OVF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_subca_ser;

  localparam int W = 4;

  logic ck    = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  subca_ser_if #(.W(W)) bus ();

  subca_ser #(.W(W)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 ck = ~ck;

  // Reference: plain integer arithmetic; bit W is the borrow-out.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    int diff;
    diff = int'(x) - int'(y) - int'(bi);
    return {(diff < 0), W'(diff)};
  endfunction

  // Overflow: true signed result falls outside the W-bit two's complement range.
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic bi);
    int sx, sy, r;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    r  = sx - sy - int'(bi);
    return (r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1);
  endfunction

  // Called at a negedge; returns at the negedge after start was sampled.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tbin);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tbv;
    bus.bin   = tbin;
    @(posedge ck);
    @(negedge ck);
    bus.start = 1'b0;
  endtask

  // Counts busy cycles until done (bounded); held=0 if outputs moved or busy dropped.
  task automatic wait_done(input bit scramble, output int cycles, output bit held);
    logic [W-1:0] q0;
    logic         b0;
    q0     = bus.q;
    b0     = bus.bout;
    cycles = 0;
    held   = 1'b1;
    while (!bus.done && cycles < 3*W) begin
      if (!bus.busy || bus.q !== q0 || bus.bout !== b0) held = 1'b0;
      cycles++;
      if (scramble) begin
        bus.start = 1'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
      end
      @(posedge ck);
      @(negedge ck);
    end
    if (scramble) bus.start = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.bout, bus.q} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got busy=%b done=%b bout=%b q=%h, want all 0",
               bus.busy, bus.done, bus.bout, bus.q);
    end
`ifdef SUBCA_SER_OVF_EN
    n_checks++;
    if (bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b want 0", bus.ovf);
    end
`endif
    bus.start = 1'b1;
    bus.a     = 4'h3;
    bus.b     = 4'h1;
    bus.bin   = 1'b0;
    repeat (2) @(posedge ck);
    @(negedge ck);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic test_basic;
    int cyc;
    bit held;
    launch(4'h5, 4'hA, 1'b0);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_start_busy: got %b want 1", bus.busy);
    end
    wait_done(1'b0, cyc, held);
    n_checks++;
    if (cyc !== W || held !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d busy cycles held=%b, want %0d held=1", cyc, held, W);
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== 4'hB || bus.bout !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_result: got done=%b busy=%b q=%h bout=%b, want 1 0 b 1",
               bus.done, bus.busy, bus.q, bus.bout);
    end
    @(posedge ck);
    @(negedge ck);
    n_checks++;
    if (bus.done !== 1'b0 || bus.q !== 4'hB) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b q=%h, want 0 b", bus.done, bus.q);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit held;
    launch(4'hF, 4'h1, 1'b0);
    wait_done(1'b0, cyc, held);
    n_checks++;
    if (bus.done !== 1'b1 || bus.q !== 4'hE || bus.bout !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b q=%h bout=%b, want 1 e 0", bus.done, bus.q, bus.bout);
    end
    launch(4'h0, 4'h0, 1'b1);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: got done=%b busy=%b, want 0 1", bus.done, bus.busy);
    end
    wait_done(1'b0, cyc, held);
    n_checks++;
    if (cyc !== W || held !== 1'b1 || bus.q !== 4'hF || bus.bout !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got cyc=%0d held=%b q=%h bout=%b, want %0d 1 f 1",
               cyc, held, bus.q, bus.bout, W);
    end
  endtask

  task automatic test_ovf;
    int cyc;
    bit held;
    launch(4'h7, 4'hF, 1'b0);
    wait_done(1'b0, cyc, held);
    n_checks++;
    if (bus.q !== 4'h8 || bus.bout !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_case1: got q=%h bout=%b, want 8 1", bus.q, bus.bout);
    end
`ifdef SUBCA_SER_OVF_EN
    n_checks++;
    if (bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag1: got %b want 1", bus.ovf);
    end
`endif
    launch(4'h3, 4'h1, 1'b0);
    wait_done(1'b0, cyc, held);
    n_checks++;
    if (bus.q !== 4'h2 || bus.bout !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_case2: got q=%h bout=%b, want 2 0", bus.q, bus.bout);
    end
`ifdef SUBCA_SER_OVF_EN
    n_checks++;
    if (bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_flag2: got %b want 0", bus.ovf);
    end
`endif
  endtask

  task automatic test_ignore_busy;
    int pulses;
    logic [W-1:0] qs;
    logic bs;
    pulses = 0;
    qs     = 'x;
    bs     = 1'bx;
    launch(4'h9, 4'h9, 1'b0);
    bus.start = 1'b1;
    bus.a     = 4'h0;
    @(posedge ck);
    @(negedge ck);
    bus.start = 1'b0;
    for (int i = 0; i < 3*W; i++) begin
      if (bus.done === 1'b1) begin
        pulses++;
        qs = bus.q;
        bs = bus.bout;
      end
      @(posedge ck);
      @(negedge ck);
    end
    n_checks++;
    if (pulses !== 1 || qs !== 4'h0 || bs !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_busy: got pulses=%0d q=%h bout=%b, want 1 0 0", pulses, qs, bs);
    end
  endtask

  task automatic test_reset_abort;
    int cyc;
    bit held;
    int pulses;
    launch(4'h7, 4'hF, 1'b0);
    wait_done(1'b0, cyc, held);
    launch(4'h5, 4'hA, 1'b0);
    @(posedge ck);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.bout, bus.q} !== '0) begin
      n_fail++;
      $display("FAIL abort_async: got busy=%b done=%b bout=%b q=%h, want all 0",
               bus.busy, bus.done, bus.bout, bus.q);
    end
    pulses = 0;
    for (int i = 0; i < 2*W; i++) begin
      @(negedge ck);
      if (bus.done !== 1'b0 || bus.q !== '0) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d cycles with done/q active, want 0", pulses);
    end
    rst_n = 1'b1;
    launch(4'h5, 4'hA, 1'b0);
    wait_done(1'b0, cyc, held);
    n_checks++;
    if (cyc !== W || bus.q !== 4'hB || bus.bout !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_restart: got cyc=%0d q=%h bout=%b, want %0d b 1",
               cyc, bus.q, bus.bout, W);
    end
  endtask

  task automatic test_random;
    int cyc;
    bit held;
    logic [W-1:0] ra, rb;
    logic rbi;
    logic [W:0] exp;
    for (int n = 0; n < 30; n++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom);
      exp = ref_sub(ra, rb, rbi);
      launch(ra, rb, rbi);
      wait_done(1'b1, cyc, held);
      n_checks++;
      if (cyc !== W || held !== 1'b1 || bus.q !== exp[W-1:0] || bus.bout !== exp[W]) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h b=%h bin=%b got cyc=%0d held=%b q=%h bout=%b, want %0d 1 %h %b",
                 n, ra, rb, rbi, cyc, held, bus.q, bus.bout, W, exp[W-1:0], exp[W]);
      end
`ifdef SUBCA_SER_OVF_EN
      n_checks++;
      if (bus.ovf !== ref_ovf(ra, rb, rbi)) begin
        n_fail++;
        $display("FAIL random_ovf_%0d: a=%h b=%h bin=%b got %b want %b",
                 n, ra, rb, rbi, bus.ovf, ref_ovf(ra, rb, rbi));
      end
`endif
      repeat ($urandom_range(0, 2)) begin
        @(posedge ck);
        @(negedge ck);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ovf();
    test_ignore_busy();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
